// File: rtl/rv32m_muldiv.sv
// RV32M multiply/divide unit: 32 iterations of a 33-bit add/subtract,
// RISC-V sign and corner-case handling, result held until accepted.
module rv32m_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam logic [2:0] OpMul    = 3'b000;
   localparam logic [2:0] OpMulh   = 3'b001;
   localparam logic [2:0] OpMulhsu = 3'b010;
   localparam logic [2:0] OpDiv    = 3'b100;
   localparam logic [2:0] OpRem    = 3'b110;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic        special_q, special_d;
   logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
   logic [31:0] acc_q, acc_d;          // product high half / partial remainder
   logic [31:0] lo_q, lo_d;            // product low half / quotient
   logic [31:0] spec_val_q, spec_val_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] result_q, result_d;

   logic        a_signed, b_signed, in_sign_a, in_sign_b;
   logic [31:0] in_mag_a, in_mag_b;
   logic        div_zero, div_ovf;
   logic [32:0] mul_sum, div_shift, div_trial;
   logic [63:0] prod, prod_neg;
   logic [31:0] quo_fix, rem_fix, fix_val;

   assign in_ready  = (state_q == StIdle) && rst_n;
   assign out_valid = out_valid_q;
   assign result    = result_q;

   // Operand decode: signedness, magnitudes and corner cases for an incoming op
   always_comb begin
      a_signed  = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
      b_signed  = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
      in_sign_a = a_signed && a[31];
      in_sign_b = b_signed && b[31];
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      in_mag_a  = in_sign_a ? (32'd0 - a) : a;
      in_mag_b  = in_sign_b ? (32'd0 - b) : b;
      div_zero  = op[2] && (b == 32'd0);
      div_ovf   = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   end

   // One iteration of shift-add multiply and restoring divide, plus final fix-up
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_a_q} : 33'd0);
      div_shift = {acc_q, lo_q[31]};
      div_trial = div_shift - {1'b0, mag_b_q};
      prod      = {acc_q, lo_q};
      prod_neg  = (sign_a_q ^ sign_b_q) ? (64'd0 - prod) : prod;
      quo_fix   = (sign_a_q ^ sign_b_q) ? (32'd0 - lo_q) : lo_q;
      rem_fix   = sign_a_q ? (32'd0 - acc_q) : acc_q;
      if (special_q) begin
         fix_val = spec_val_q;
      end else if (!op_q[2]) begin
         fix_val = (op_q == OpMul) ? prod_neg[31:0] : prod_neg[63:32];
      end else begin
         fix_val = op_q[1] ? rem_fix : quo_fix;
      end
   end

   // Next-state logic for the control FSM and datapath registers
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      special_d   = special_q;
      mag_a_d     = mag_a_q;
      mag_b_d     = mag_b_q;
      acc_d       = acc_q;
      lo_d        = lo_q;
      spec_val_d  = spec_val_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               op_d       = op;
               sign_a_d   = in_sign_a;
               sign_b_d   = in_sign_b;
               mag_a_d    = in_mag_a;
               mag_b_d    = in_mag_b;
               acc_d      = 32'd0;
               lo_d       = op[2] ? in_mag_a : in_mag_b;
               cnt_d      = 5'd0;
               special_d  = div_zero || div_ovf;
               if (div_zero) begin
                  spec_val_d = op[1] ? a : 32'hFFFF_FFFF;
               end else begin
                  spec_val_d = op[1] ? 32'd0 : 32'h8000_0000;
               end
               state_d    = (div_zero || div_ovf) ? StFix : StCalc;
            end
         end
         StCalc: begin
            if (!op_q[2]) begin
               acc_d = mul_sum[32:1];
               lo_d  = {mul_sum[0], lo_q[31:1]};
            end else if (!div_trial[32]) begin
               acc_d = div_trial[31:0];
               lo_d  = {lo_q[30:0], 1'b1};
            end else begin
               acc_d = div_shift[31:0];
               lo_d  = {lo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d    = fix_val;
            out_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
         result_d    = 32'd0;
         cnt_d       = 5'd0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= 3'd0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         special_q   <= 1'b0;
         mag_a_q     <= 32'd0;
         mag_b_q     <= 32'd0;
         acc_q       <= 32'd0;
         lo_q        <= 32'd0;
         spec_val_q  <= 32'd0;
         cnt_q       <= 5'd0;
         out_valid_q <= 1'b0;
         result_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         special_q   <= special_d;
         mag_a_q     <= mag_a_d;
         mag_b_q     <= mag_b_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         spec_val_q  <= spec_val_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed-vector bench for rv32m_muldiv.
module tb_rv32m_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   rv32m_muldiv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an op and wait (bounded) for the accept edge; returns just after it
   task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      int n;
      op = o; a = x; b = y; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid after an accept, check latency, in_ready and result
   task automatic await(input string tag, input logic [31:0] exp, input int exp_lat);
      int lat;
      logic ir_seen;
      lat = 0;
      ir_seen = 1'b0;
      while (!out_valid && lat < 60) begin
         if (in_ready) ir_seen = 1'b1;
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " in_ready busy"}, 32'(ir_seen), 32'd0);
      check({tag, " result"}, result, exp);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready rise"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
      issue(tag, o, x, y);
      await(tag, exp, exp_lat);
      drain(tag);
   endtask

   initial begin
      logic [31:0] held;
      logic        seen;

      // Reset behaviour
      step();
      step();
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", result, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post rst in_ready", 32'(in_ready), 32'd1);

      // Multiply
      run("mul 7*-3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run("mulh min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
      run("mulhu max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run("mulhsu max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run("mul min",     3'b000, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 33);

      // Divide
      run("div -7/2",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
      run("rem -7/2",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
      run("divu 100/7",  3'b101, 32'd100,        32'd7,         32'd14,        33);
      run("remu 100/7",  3'b111, 32'd100,        32'd7,         32'd2,         33);
      run("divu max/1",  3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);

      // Special cases
      run("div 5/0",     3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      run("rem 5/0",     3'b110, 32'd5,          32'd0,         32'd5,         1);
      run("divu 5/0",    3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      run("div ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("rem ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Backpressure, then a back-to-back op held on in_valid
      issue("bp", 3'b000, 32'd6, 32'd9);
      await("bp", 32'd54, 33);
      held = result;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!out_valid || in_ready || result !== held) seen = 1'b1;
         step();
      end
      check("bp hold", 32'(seen), 32'd0);
      check("bp held result", result, 32'd54);
      out_ready = 1'b1;
      op = 3'b101; a = 32'd1000; b = 32'd10; in_valid = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp out_valid drop", 32'(out_valid), 32'd0);
      check("bp in_ready rise", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("bp next accepted", 32'(in_ready), 32'd0);
      await("bp next", 32'd100, 33);
      drain("bp next");

      // Flush in the 10th CALC cycle
      issue("flush", 3'b101, 32'd100, 32'd3);
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("flush no out_valid", 32'(seen), 32'd0);
      run("after flush", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

      // Reset in the 20th CALC cycle; previous result is nonzero
      issue("rst", 3'b000, 32'd3, 32'd5);
      for (int i = 0; i < 19; i++) step();
      rst_n = 1'b0;
      step();
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst result", result, 32'd0);
      check("mid rst in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("mid rst in_ready up", 32'(in_ready), 32'd1);
      run("after rst", 3'b111, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
